renkon_pool_window: RTL and testbench
=====================================

// Module: renkon_pool_window
// PURPOSE
//  Upstream feeder for the 2x2/stride-2 max-pool stage. Accepts a raster-order
//  pixel stream (row-major, one pixel per valid cycle) and emits one 2x2 window
//  as pixel_feat0..3 per completed window. Ends with the out_en strobe that the
//  pool stage consumes. Sits between the convolution output mux and renkon_pool_max.
// PARAMETERS
//  DWIDTH   16    pixel width, signed two's complement (from renkon.vh)
//  MAXW     256   largest supported image width in pixels
//  SZWIDTH  9     width of w_size/h_size, clog2(MAXW)+1
// PORTS
//  clk          in   1        rising-edge clock
//  xrst         in   1        asynchronous active-low reset
//  init         in   1        1-cycle pulse: latch sizes, start a new image
//  w_size       in   SZWIDTH  image width, sampled on init
//  h_size       in   SZWIDTH  image height, sampled on init
//  pixel_valid  in   1        pixel_in valid this cycle; no backpressure
//  pixel_in     in   DWIDTH   signed input pixel
//  pixel_feat0  out  DWIDTH   window top-left     (row 2r,   col 2c)
//  pixel_feat1  out  DWIDTH   window top-right    (row 2r,   col 2c+1)
//  pixel_feat2  out  DWIDTH   window bottom-left  (row 2r+1, col 2c)
//  pixel_feat3  out  DWIDTH   window bottom-right (row 2r+1, col 2c+1)
//  out_en       out  1        strobe for the pool stage's result register
//  ack          out  1        high when idle or image complete
// BEHAVIOUR
//  - Reset (xrst=0, async): state IDLE, counters 0, feats 0, out_en 0, ack 1.
//    Line buffer contents are don't-care after reset.
//  - FSM IDLE -> RUN on init. RUN -> DONE when pixel (h_size-1, w_size-1) is
//    accepted. DONE -> RUN on init. init in any state restarts the image:
//    counters cleared, sizes relatched, no window pending.
//    ack = (state != RUN).
//  - Pixels with pixel_valid in IDLE/DONE are ignored.
//  - col/row counters advance on accepted pixels. col wraps at w_size-1 and row
//    increments on the wrap.
//  - Even row: pixel written to linebuf[col]. Odd row, even col: pixel held in
//    a left register.
//  - Odd row, odd col, inside the floor bound: a window completes at accept
//    cycle T.
//    - T+1: feat0=linebuf[col-1], feat1=linebuf[col], feat2=left, feat3=pixel.
//    - T+2: out_en=1 for exactly one cycle. This matches the pool stage's
//      internal feat register delay.
//    - Feats hold until the next window completes.
//  - Odd w_size/h_size: last column/row is consumed but yields no window
//    (floor). Window count = floor(w/2)*floor(h/2).
//  - w_size<2 or h_size<2: no windows. The FSM still reaches DONE after w*h
//    pixels.
//  - w_size>MAXW is unsupported; behaviour undefined.
//  - Back-to-back valid pixels give at most one out_en per 2 cycles. Gaps in
//    pixel_valid only delay windows.
//  - Reset mid-image: everything returns to reset values immediately. A pending
//    out_en is dropped.
//  - Values pass through unmodified. No arithmetic on pixel data. Sign preserved.
// STRUCTURE
//  - DWIDTH and the shared pool constants live in renkon.vh. Bus/size widths
//    live in ninjin.vh. FSM state encodings are localparams in this file.
//  - One sub-module, renkon_pool_linebuf: MAXW x DWIDTH single-write,
//    single-read RAM, synchronous read, one cycle. The read address is issued on
//    the odd-row even-col pixel so that linebuf[col-1..col] are available at T.
//    The second word is read at T as well, or both are registered as a pair.
// TESTING
//  1. 4x4 image, pixels 0..15 contiguous
//     -> 4 out_en pulses; feats (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15);
//        ack returns 1 after pixel 15.
//  2. Same 4x4 image with pixel_valid toggling every other cycle
//     -> identical windows; out_en exactly 2 cycles after each completing pixel.
//  3. 5x3 image, pixels 0..14
//     -> 2 windows: (0,1,5,6),(2,3,7,8); column 4 and row 2 produce none;
//        DONE after 15 pixels.
//  4. Signed data: 2x2 of -32768,-1,32767,0
//     -> feats carry these exact values; chained renkon_pool_max outputs 32767.
//  5. xrst asserted after 6 pixels of a 4x4, then init + full image
//     -> no out_en from the aborted image; the new image gives the case-1 result.
//  6. init re-pulsed mid-image with w=2, h=2, pixels 7,8,9,10
//     -> exactly one window (7,8,9,10); ack=1 afterwards.

Source files
------------

// File: rtl/renkon_pool_window_pkg.sv
// Shared constants and FSM state type for the 2x2/stride-2 pool window feeder.
// Sizes default to 16-bit signed pixels and images up to 256 pixels wide.
// Imported by renkon_pool_window and renkon_pool_linebuf.
package renkon_pool_window_pkg;

  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_MAXW    = 256;
  localparam int DEF_SZWIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/renkon_pool_linebuf.sv
// One-row line buffer: single write port, single synchronous read port.
// Read latency one cycle; rdata holds its value until the next read.
// No backpressure; write and read are issued on the same accepted pixel.
module renkon_pool_linebuf
  import renkon_pool_window_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_MAXW,
  parameter int AWIDTH = $clog2(DEF_MAXW)
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage array: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/renkon_pool_window.sv
// Turns a raster pixel stream into 2x2/stride-2 windows for the max-pool stage.
// Feats appear the cycle after the completing pixel; out_en one cycle after that.
// No backpressure: pixels are taken whenever pixel_valid is high in RUN.
module renkon_pool_window
  import renkon_pool_window_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int MAXW    = DEF_MAXW,
  parameter int SZWIDTH = DEF_SZWIDTH
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               init,
  input  logic [SZWIDTH-1:0] w_size,
  input  logic [SZWIDTH-1:0] h_size,
  input  logic               pixel_valid,
  input  logic [DWIDTH-1:0]  pixel_in,
  output logic [DWIDTH-1:0]  pixel_feat0,
  output logic [DWIDTH-1:0]  pixel_feat1,
  output logic [DWIDTH-1:0]  pixel_feat2,
  output logic [DWIDTH-1:0]  pixel_feat3,
  output logic               out_en,
  output logic               ack
);

  localparam int AWIDTH = $clog2(MAXW);

  state_t              state, state_nxt;
  logic [SZWIDTH-1:0]  w_reg, h_reg;
  logic [SZWIDTH-1:0]  col, row, col_nxt;
  logic                col_last, row_last;
  logic                accept, win_hit, win_pend;
  logic [DWIDTH-1:0]   lb_rdata, hold0, left;

  // Init wins over a same-cycle pixel: that pixel belongs to no image.
  assign accept   = pixel_valid && (state == ST_RUN) && !init;
  assign col_last = (col == w_reg - SZWIDTH'(1));
  assign row_last = (row == h_reg - SZWIDTH'(1));
  assign col_nxt  = col_last ? '0 : col + SZWIDTH'(1);
  // Odd row + odd col always lies inside the floor bound, so odd trailing
  // columns/rows never produce a window.
  assign win_hit  = accept && row[0] && col[0];
  assign ack      = (state != ST_RUN);

  // State register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: init always (re)starts, last pixel of the image finishes.
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = ST_RUN;
    end else if (accept && col_last && row_last) begin
      state_nxt = ST_DONE;
    end
  end

  // Size latch and raster position counters.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      w_reg <= '0;
      h_reg <= '0;
      col   <= '0;
      row   <= '0;
    end else if (init) begin
      w_reg <= w_size;
      h_reg <= h_size;
      col   <= '0;
      row   <= '0;
    end else if (accept) begin
      col <= col_nxt;
      if (col_last) row <= row + SZWIDTH'(1);
    end
  end

  // Even rows fill the buffer. Every accepted pixel prefetches the word for the
  // next raster column, so when an odd-row pixel arrives lb_rdata already holds
  // the upper-row pixel directly above it.
  renkon_pool_linebuf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MAXW),
    .AWIDTH (AWIDTH)
  ) u_linebuf (
    .clk   (clk),
    .xrst  (xrst),
    .we    (accept && !row[0]),
    .waddr (col[AWIDTH-1:0]),
    .wdata (pixel_in),
    .re    (accept),
    .raddr (col_nxt[AWIDTH-1:0]),
    .rdata (lb_rdata)
  );

  // Left half of the window: upper-left word and the odd-row even-col pixel.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      hold0 <= '0;
      left  <= '0;
    end else if (accept && row[0] && !col[0]) begin
      hold0 <= lb_rdata;
      left  <= pixel_in;
    end
  end

  // Window output registers, loaded on the completing pixel and held.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      pixel_feat0 <= '0;
      pixel_feat1 <= '0;
      pixel_feat2 <= '0;
      pixel_feat3 <= '0;
    end else if (win_hit) begin
      pixel_feat0 <= hold0;
      pixel_feat1 <= lb_rdata;
      pixel_feat2 <= left;
      pixel_feat3 <= pixel_in;
    end
  end

  // Strobe delayed one more cycle to line up with the pool stage's feat
  // register; a restart drops anything still in flight.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      win_pend <= 1'b0;
      out_en   <= 1'b0;
    end else if (init) begin
      win_pend <= 1'b0;
      out_en   <= 1'b0;
    end else begin
      win_pend <= win_hit;
      out_en   <= win_pend;
    end
  end

endmodule

// File: tb/tb_renkon_pool_window.sv
module tb_renkon_pool_window;

  logic        clk;
  logic        xrst;
  logic        init;
  logic [8:0]  w_size, h_size;
  logic        pixel_valid;
  logic [15:0] pixel_in;
  logic [15:0] pixel_feat0, pixel_feat1, pixel_feat2, pixel_feat3;
  logic        out_en, ack;

  renkon_pool_window dut (
    .clk         (clk),
    .xrst        (xrst),
    .init        (init),
    .w_size      (w_size),
    .h_size      (h_size),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .pixel_feat0 (pixel_feat0),
    .pixel_feat1 (pixel_feat1),
    .pixel_feat2 (pixel_feat2),
    .pixel_feat3 (pixel_feat3),
    .out_en      (out_en),
    .ack         (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int c;
    int f [4];
  } win_t;

  win_t q [$];
  int   img [256];
  int   cur_w, cur_h, m_cnt, pix_i;
  bit   m_active;
  int   n_out;
  int   last_f [4];
  int   last_max;

  // Called in the cycle a pixel is presented; out_en is due two cycles later.
  task automatic model_pixel();
    int r, c;
    win_t w;
    if (!m_active) return;
    r = m_cnt / cur_w;
    c = m_cnt % cur_w;
    if ((r % 2 == 1) && (c % 2 == 1) && (c < (cur_w / 2) * 2) && (r < (cur_h / 2) * 2)) begin
      w.c    = cyc + 2;
      w.f[0] = img[(r - 1) * cur_w + c - 1];
      w.f[1] = img[(r - 1) * cur_w + c];
      w.f[2] = img[r * cur_w + c - 1];
      w.f[3] = img[m_cnt];
      q.push_back(w);
    end
    m_cnt++;
    if (m_cnt == cur_w * cur_h) m_active = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_en;
    int mx;
    exp_en = (q.size() > 0) && (q[0].c == cyc);
    chk("out_en", int'(out_en), int'(exp_en));
    if (out_en) begin
      n_out++;
      last_f[0] = $signed(pixel_feat0);
      last_f[1] = $signed(pixel_feat1);
      last_f[2] = $signed(pixel_feat2);
      last_f[3] = $signed(pixel_feat3);
      mx = last_f[0];
      for (int k = 1; k < 4; k++) if (last_f[k] > mx) mx = last_f[k];
      last_max = mx;
    end
    if (exp_en) begin
      if (out_en) begin
        chk("feat0", last_f[0], q[0].f[0]);
        chk("feat1", last_f[1], q[0].f[1]);
        chk("feat2", last_f[2], q[0].f[2]);
        chk("feat3", last_f[3], q[0].f[3]);
      end
      void'(q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_init(input int w, input int h);
    init   = 1'b1;
    w_size = 9'(w);
    h_size = 9'(h);
    while (q.size() > 0 && q[q.size() - 1].c >= cyc + 1) void'(q.pop_back());
    cur_w = w; cur_h = h; m_cnt = 0; pix_i = 0; m_active = 1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic drive_n(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      pixel_valid = 1'b1;
      pixel_in    = 16'(img[pix_i]);
      model_pixel();
      pix_i++;
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_ramp(input int n);
    for (int k = 0; k < n; k++) img[k] = k;
  endtask

  task automatic chk_last(input string name, input int a, input int b, input int c, input int d);
    chk({name, ".f0"}, last_f[0], a);
    chk({name, ".f1"}, last_f[1], b);
    chk({name, ".f2"}, last_f[2], c);
    chk({name, ".f3"}, last_f[3], d);
  endtask

  int base;

  initial begin
    xrst = 1'b0; init = 1'b0; w_size = '0; h_size = '0;
    pixel_valid = 1'b0; pixel_in = '0;
    m_active = 0; n_out = 0; last_max = 0;
    idle(2);
    chk("rst.ack", int'(ack), 1);
    chk("rst.out_en", int'(out_en), 0);
    chk("rst.feat0", int'(pixel_feat0), 0);
    chk("rst.feat3", int'(pixel_feat3), 0);
    xrst = 1'b1;
    idle(2);

    // Case 1: 4x4 contiguous.
    load_ramp(16);
    base = n_out;
    do_init(4, 4);
    chk("c1.ack_busy", int'(ack), 0);
    drive_n(16, 0);
    chk("c1.ack_done", int'(ack), 1);
    idle(4);
    chk("c1.windows", n_out - base, 4);
    chk_last("c1.last", 10, 11, 14, 15);
    // Pixels after completion are ignored.
    base = n_out;
    pixel_valid = 1'b1; pixel_in = 16'd99;
    idle(4);
    pixel_valid = 1'b0;
    idle(3);
    chk("c1.post_done", n_out - base, 0);
    chk("c1.ack_hold", int'(ack), 1);

    // Case 2: same image, valid every other cycle.
    base = n_out;
    do_init(4, 4);
    drive_n(16, 1);
    idle(4);
    chk("c2.windows", n_out - base, 4);
    chk_last("c2.last", 10, 11, 14, 15);

    // Case 3: 5x3, odd width and height.
    load_ramp(15);
    base = n_out;
    do_init(5, 3);
    drive_n(14, 0);
    chk("c3.ack_before_last", int'(ack), 0);
    drive_n(1, 0);
    chk("c3.ack_done", int'(ack), 1);
    idle(4);
    chk("c3.windows", n_out - base, 2);
    chk_last("c3.last", 2, 3, 7, 8);

    // Case 4: signed extremes.
    img[0] = -32768; img[1] = -1; img[2] = 32767; img[3] = 0;
    base = n_out;
    do_init(2, 2);
    drive_n(4, 0);
    idle(4);
    chk("c4.windows", n_out - base, 1);
    chk_last("c4.last", -32768, -1, 32767, 0);
    chk("c4.pool_max", last_max, 32767);

    // Case 5: reset after 6 pixels (pixel 5 completes a window that must be dropped).
    load_ramp(16);
    base = n_out;
    do_init(4, 4);
    drive_n(6, 0);
    xrst = 1'b0;
    q.delete();
    m_active = 0;
    #1;
    chk("c5.rst_out_en", int'(out_en), 0);
    chk("c5.rst_ack", int'(ack), 1);
    chk("c5.rst_feat1", int'(pixel_feat1), 0);
    idle(3);
    chk("c5.aborted_windows", n_out - base, 0);
    xrst = 1'b1;
    idle(1);
    base = n_out;
    do_init(4, 4);
    drive_n(16, 0);
    idle(4);
    chk("c5.windows", n_out - base, 4);
    chk_last("c5.last", 10, 11, 14, 15);

    // Case 6: restart mid-image as 2x2.
    img[0] = 7; img[1] = 8; img[2] = 9; img[3] = 10;
    base = n_out;
    do_init(4, 4);
    drive_n(3, 0);
    do_init(2, 2);
    chk("c6.ack_busy", int'(ack), 0);
    drive_n(4, 0);
    idle(4);
    chk("c6.windows", n_out - base, 1);
    chk_last("c6.last", 7, 8, 9, 10);
    chk("c6.ack_done", int'(ack), 1);

    // Case 7: width 1 gives no windows but still completes.
    load_ramp(3);
    base = n_out;
    do_init(1, 3);
    drive_n(3, 0);
    chk("c7.ack_done", int'(ack), 1);
    idle(4);
    chk("c7.windows", n_out - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
